// File: rtl/store_data_packer_if.sv
// Request and data-memory write bus of the store data packer.
// The packer uses the slave modport; the requester/memory side uses master.
interface store_data_packer_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_data;
   logic [1:0]            req_size;
   logic                  mem_we;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_be;
   logic                  st_done;
   logic                  misalign_err;

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ready,
      output req_ready, mem_we, mem_addr, mem_wdata, mem_be, st_done, misalign_err
   );

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ready,
      input  req_ready, mem_we, mem_addr, mem_wdata, mem_be, st_done, misalign_err
   );
endinterface

// File: rtl/store_data_packer.sv
// Narrows a register value to byte/half/word and lane-aligns it onto a word-addressed write port;
// stores crossing a word boundary go out as two beats. Optional macro: STORE_PACKER_MISALIGN_TRAP_EN.
module store_data_packer #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   store_data_packer_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t      state;
   logic        spill_q;
   logic [3:0]  be_hi;
   logic [31:0] data_hi;

   logic [1:0]  off;
   logic [3:0]  mask;
   logic [2:0]  nbytes;
   logic [31:0] data_n;
   logic        spill;
   logic [7:0]  be_wide;
   logic [63:0] data_wide;
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   assign bus.req_ready = (state == IDLE) && !rst;

   // Placing the masked value in a double-word window gives both beats at once:
   // the low half is the first beat, the high half is whatever spilled over.
   always_comb begin
      off    = bus.req_addr[1:0];
      mask   = 4'b0000;
      nbytes = 3'd0;
      data_n = 32'h0000_0000;
      case (bus.req_size)
         2'b00: begin
            mask   = 4'b0001;
            nbytes = 3'd1;
            data_n = {24'h00_0000, bus.req_data[7:0]};
         end
         2'b01: begin
            mask   = 4'b0011;
            nbytes = 3'd2;
            data_n = {16'h0000, bus.req_data[15:0]};
         end
         2'b10: begin
            mask   = 4'b1111;
            nbytes = 3'd4;
            data_n = bus.req_data;
         end
         default: begin
            mask   = 4'b0000;
            nbytes = 3'd0;
            data_n = 32'h0000_0000;
         end
      endcase
      spill     = (({1'b0, off} + nbytes) > 3'd4);
      be_wide   = {4'b0000, mask} << off;
      data_wide = {32'h0000_0000, data_n} << {off, 3'b000};
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
      misaligned = ((bus.req_size == 2'b01) && off[0]) ||
                   ((bus.req_size == 2'b10) && (off != 2'b00));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         spill_q       <= 1'b0;
         be_hi         <= 4'b0000;
         data_hi       <= 32'h0000_0000;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0000_0000;
         bus.mem_be    <= 4'b0000;
         bus.st_done   <= 1'b0;
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
         bus.misalign_err <= 1'b0;
`endif
      end else begin
         bus.st_done <= 1'b0;
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
         bus.misalign_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (bus.req_size == 2'b11) begin
                     bus.st_done <= 1'b1;
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
                  end else if (misaligned) begin
                     bus.misalign_err <= 1'b1;
`endif
                  end else begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                     bus.mem_be    <= be_wide[3:0];
                     bus.mem_wdata <= data_wide[31:0];
                     be_hi         <= be_wide[7:4];
                     data_hi       <= data_wide[63:32];
                     spill_q       <= spill;
                     state         <= BEAT0;
                  end
               end
            end
            BEAT0: begin
               if (bus.mem_ready) begin
                  if (spill_q) begin
                     bus.mem_addr  <= bus.mem_addr + ADDR_WIDTH'(4);
                     bus.mem_be    <= be_hi;
                     bus.mem_wdata <= data_hi;
                     state         <= BEAT1;
                  end else begin
                     bus.mem_we    <= 1'b0;
                     bus.mem_be    <= 4'b0000;
                     bus.mem_wdata <= 32'h0000_0000;
                     bus.st_done   <= 1'b1;
                     state         <= IDLE;
                  end
               end
            end
            BEAT1: begin
               if (bus.mem_ready) begin
                  bus.mem_we    <= 1'b0;
                  bus.mem_be    <= 4'b0000;
                  bus.mem_wdata <= 32'h0000_0000;
                  bus.st_done   <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef STORE_PACKER_MISALIGN_TRAP_EN
   assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_data_packer.sv
// Scoreboard bench for store_data_packer: expected beats and completions are queued
// from a byte-by-byte model when a request is driven and checked as the DUT produces them.
module tb_store_data_packer;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   readyMode;
   int   stallCount;
   beat_t beatQ[$];
   int    doneQ[$];

   store_data_packer_if #(.ADDR_WIDTH(32)) bus();

   store_data_packer #(.ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Each byte is placed by its own absolute address, so a store crossing a word
   // boundary naturally lands in the following word.
   task automatic pushExpected(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      int nb;
      int pos;
      logic [3:0]  be0, be1;
      logic [31:0] wd0, wd1;
      logic [31:0] base;
      if (size == 2'b11) begin
         doneQ.push_back(0);
         return;
      end
`ifdef STORE_PACKER_MISALIGN_TRAP_EN
      if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
         doneQ.push_back(1);
         return;
      end
`endif
      nb  = 1 << size;
      be0 = 4'b0000;
      be1 = 4'b0000;
      wd0 = 32'h0;
      wd1 = 32'h0;
      for (int i = 0; i < nb; i++) begin
         pos = int'(addr[1:0]) + i;
         if (pos < 4) begin
            be0[pos]         = 1'b1;
            wd0[8*pos +: 8]  = data[8*i +: 8];
         end else begin
            be1[pos-4]           = 1'b1;
            wd1[8*(pos-4) +: 8]  = data[8*i +: 8];
         end
      end
      base = {addr[31:2], 2'b00};
      beatQ.push_back('{addr: base, be: be0, wdata: wd0});
      if (be1 != 4'b0000) beatQ.push_back('{addr: base + 32'd4, be: be1, wdata: wd1});
      doneQ.push_back(0);
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checkOutput("ready_timeout", 64'd0, 64'd1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_data  = data;
      bus.req_size  = size;
      pushExpected(addr, data, size);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_data  = $urandom;
      bus.req_size  = 2'($urandom_range(0, 3));
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((beatQ.size() != 0 || doneQ.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (beatQ.size() != 0 || doneQ.size() != 0) begin
         checkOutput("drain_timeout", 64'(beatQ.size() + doneQ.size()), 64'd0);
         beatQ.delete();
         doneQ.delete();
      end
   endtask

   // Memory side: always ready, a fixed stall per beat, or held off entirely.
   initial begin
      stallCount = 0;
      forever begin
         @(negedge clk);
         if (readyMode == 0) begin
            bus.mem_ready = 1'b1;
         end else if (readyMode == 2) begin
            bus.mem_ready = 1'b0;
         end else if (bus.mem_we && !bus.mem_ready) begin
            if (stallCount == 3) bus.mem_ready = 1'b1;
            else stallCount++;
         end else begin
            bus.mem_ready = 1'b0;
            stallCount    = 0;
         end
      end
   end

   // Every cycle a beat is presented it must equal the queue head, which also
   // checks that outputs hold steady while the memory stalls.
   initial begin
      beat_t b;
      int    k;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (bus.mem_we) begin
               if (beatQ.size() == 0) begin
                  checkOutput("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  b = beatQ[0];
                  checkOutput("beat_addr", 64'(bus.mem_addr), 64'(b.addr));
                  checkOutput("beat_be", 64'(bus.mem_be), 64'(b.be));
                  checkOutput("beat_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
                  if (bus.mem_ready) void'(beatQ.pop_front());
               end
            end
            if (bus.st_done || bus.misalign_err) begin
               checkOutput("done_we_low", 64'(bus.mem_we), 64'd0);
               checkOutput("done_ready", 64'(bus.req_ready), 64'd1);
               checkOutput("done_both", 64'(bus.st_done & bus.misalign_err), 64'd0);
               if (doneQ.size() == 0) begin
                  checkOutput("unexpected_done", 64'd1, 64'd0);
               end else begin
                  k = doneQ.pop_front();
                  checkOutput("done_kind", 64'(bus.misalign_err), 64'(k));
               end
            end
         end
      end
   end

   initial begin
      checks         = 0;
      errors         = 0;
      readyMode      = 0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_data   = 32'h0;
      bus.req_size   = 2'b00;
      bus.mem_ready  = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_we", 64'(bus.mem_we), 64'd0);
      checkOutput("rst_addr", 64'(bus.mem_addr), 64'd0);
      checkOutput("rst_wdata", 64'(bus.mem_wdata), 64'd0);
      checkOutput("rst_be", 64'(bus.mem_be), 64'd0);
      checkOutput("rst_done", 64'(bus.st_done), 64'd0);
      checkOutput("rst_err", 64'(bus.misalign_err), 64'd0);
      checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", 64'(bus.req_ready), 64'd1);

      $display("[TB] directed stores");
      applyStimulus(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
      waitIdle();
      applyStimulus(32'h0000_1003, 32'h1234_56AB, 2'b00);
      waitIdle();
      applyStimulus(32'h0000_2003, 32'h0000_CAFE, 2'b01);
      waitIdle();

      $display("[TB] backpressure and address wrap");
      readyMode = 1;
      applyStimulus(32'hFFFF_FFFE, 32'hDEAD_BEEF, 2'b10);
      waitIdle();
      readyMode = 0;

      $display("[TB] reset mid-store");
      readyMode = 2;
      applyStimulus(32'h0000_3000, 32'h1122_3344, 2'b10);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_we", 64'(bus.mem_we), 64'd0);
      checkOutput("midrst_be", 64'(bus.mem_be), 64'd0);
      checkOutput("midrst_done", 64'(bus.st_done), 64'd0);
      checkOutput("midrst_ready", 64'(bus.req_ready), 64'd0);
      beatQ.delete();
      doneQ.delete();
      readyMode = 0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("postrst_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("postrst_done", 64'(bus.st_done), 64'd0);

      $display("[TB] back-to-back illegal size then byte");
      applyStimulus(32'h0000_4000, 32'hFFFF_FFFF, 2'b11);
      applyStimulus(32'h0000_4001, 32'h0000_0077, 2'b00);
      waitIdle();

      $display("[TB] random stores");
      for (int i = 0; i < 24; i++) begin
         readyMode = $urandom_range(0, 1);
         applyStimulus($urandom, $urandom, 2'($urandom_range(0, 3)));
      end
      waitIdle();
      readyMode = 0;
      repeat (3) @(negedge clk);
      checkOutput("final_beatq", 64'(beatQ.size()), 64'd0);
      checkOutput("final_doneq", 64'(doneQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
